pio_in_filter: RTL

- Input-conditioning stage directly upstream of the PIO block's `idata` input.
- Per pin: synchronises the raw input, debounces it with a programmable stability count, and drives the clean level to PIO `idata`.
- Per pin: detects rising and falling edges on the clean level and keeps sticky pending flags.
- Drives a single level interrupt for the system interrupt controller.

---
 rtl/pio_in_filter.sv | 58 +++++
 1 files changed

// File: rtl/pio_in_filter.sv
// pio_in_filter: per-pin synchroniser, debouncer and edge detector with sticky
// pending flags, feeding PIO idata and a single level interrupt.
module pio_in_filter #(
   parameter int pioWidth = 10,
   parameter int cntWidth = 8
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [pioWidth-1:0] pin_i,
   input  logic [cntWidth-1:0] cfg_debounce,
   input  logic [pioWidth-1:0] cfg_rise_en,
   input  logic [pioWidth-1:0] cfg_fall_en,
   input  logic [pioWidth-1:0] pend_clr,
   output logic [pioWidth-1:0] idata,
   output logic [pioWidth-1:0] rise,
   output logic [pioWidth-1:0] fall,
   output logic [pioWidth-1:0] pending,
   output logic                irq
);
   logic [pioWidth-1:0] s1, s2, hit, rise_nxt, fall_nxt;
   logic [cntWidth-1:0] cnt [pioWidth];

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= pin_i;
         s2 <= s1;
      end

   // >= lets a lowered threshold release a counter already past it
   for (genvar i = 0; i < pioWidth; i++) begin : g_pin
      assign hit[i] = (s2[i] != idata[i]) && (cnt[i] >= cfg_debounce);
      always_ff @(posedge clk or negedge reset_n)
         if (!reset_n) cnt[i] <= '0;
         else cnt[i] <= (s2[i] == idata[i] || hit[i]) ? '0 : (&cnt[i] ? cnt[i] : cnt[i] + 1'b1);
   end

   assign rise_nxt = hit & s2;
   assign fall_nxt = hit & ~s2;

   // set is OR-ed in after the clear so a coincident edge is never lost
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         idata   <= '0;
         rise    <= '0;
         fall    <= '0;
         pending <= '0;
      end else begin
         idata   <= idata ^ hit;
         rise    <= rise_nxt;
         fall    <= fall_nxt;
         pending <= (pending & ~pend_clr) | (rise_nxt & cfg_rise_en) | (fall_nxt & cfg_fall_en);
      end

   assign irq = |pending;
endmodule
